// File: rtl/johnson_decoder.sv
// Registered decoder and successor checker for an N-bit Johnson count.
// Produces binary index, one-hot, legality/sequence flags, lock status and a saturating error count.
module johnson_decoder #(
    parameter  int N        = 3,
    parameter  int LOCK_CNT = 4,
    localparam int W        = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [N-1:0]     jc_in,
    output logic [W-1:0]     bin_out,
    output logic [2*N-1:0]   onehot_out,
    output logic             valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

    localparam logic [3:0]   LOCK_MAX = 4'(LOCK_CNT);
    localparam logic [W-1:0] LAST_IDX = W'(2 * N - 1);

    state_t       r_state;
    logic [3:0]   r_adv;
    logic [W-1:0] r_ref;

    logic         w_legal;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_succ;
    logic         w_is_succ;
    logic         w_is_hold;
    logic [3:0]   w_adv_inc;
    logic [7:0]   w_err_inc;

    // Johnson code for index idx: MSB-first fill for idx<=N, then drain from the MSB side.
    function automatic logic [N-1:0] code_of(input int idx);
        logic [N-1:0] c;
        c = '0;
        for (int b = 0; b < N; b++) begin
            if (idx <= N) c[b] = (b >= N - idx);
            else          c[b] = (b < 2 * N - idx);
        end
        return c;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (jc_in == code_of(i)) begin
                w_legal = 1'b1;
                w_idx   = W'(i);
            end
        end
    end

    assign w_succ    = (r_ref == LAST_IDX) ? '0 : r_ref + W'(1);
    assign w_is_succ = (w_idx == w_succ);
    assign w_is_hold = (w_idx == r_ref);
    assign w_adv_inc = (r_adv == LOCK_MAX) ? r_adv : r_adv + 4'd1;
    assign w_err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign locked    = (r_state == LOCKED);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= SEEK;
            r_adv      <= '0;
            r_ref      <= '0;
            bin_out    <= '0;
            onehot_out <= '0;
            valid      <= 1'b0;
            illegal    <= 1'b0;
            seq_err    <= 1'b0;
            wrap       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            seq_err <= 1'b0;
            wrap    <= 1'b0;
            if (en) begin
                if (!w_legal) begin
                    illegal    <= 1'b1;
                    valid      <= 1'b0;
                    onehot_out <= '0;
                    err_cnt    <= w_err_inc;
                    r_state    <= SEEK;
                    r_adv      <= '0;
                end else begin
                    illegal    <= 1'b0;
                    valid      <= 1'b1;
                    bin_out    <= w_idx;
                    onehot_out <= (2 * N)'(1) << w_idx;
                    if (r_state == SEEK) begin
                        r_ref   <= w_idx;
                        r_adv   <= '0;
                        r_state <= TRACK;
                    end else if (w_is_hold) begin
                        r_ref <= r_ref;
                    end else if (w_is_succ) begin
                        r_ref <= w_idx;
                        r_adv <= w_adv_inc;
                        if (w_adv_inc == LOCK_MAX) r_state <= LOCKED;
                        if (r_ref == LAST_IDX)     wrap    <= 1'b1;
                    end else begin
                        seq_err <= 1'b1;
                        err_cnt <= w_err_inc;
                        r_ref   <= w_idx;
                        r_adv   <= '0;
                        r_state <= TRACK;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=3, LOCK_CNT=4): vector table plus reset and saturation sequences.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [2:0] jc_in;
    logic [2:0] bin_out;
    logic [5:0] onehot_out;
    logic       valid, illegal, seq_err, wrap, locked;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [2:0] jc;
        logic [2:0] bin;
        logic [5:0] oh;
        logic       valid;
        logic       ill;
        logic       seq;
        logic       wrap;
        logic       lock;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[$];

    johnson_decoder #(.N(3), .LOCK_CNT(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .jc_in      (jc_in),
        .bin_out    (bin_out),
        .onehot_out (onehot_out),
        .valid      (valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .wrap       (wrap),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [2:0] j, input logic [2:0] b,
                                input logic [5:0] o, input logic v, input logic il,
                                input logic s, input logic w, input logic l, input logic [7:0] er);
        vec_t t;
        t.en = e; t.jc = j; t.bin = b; t.oh = o; t.valid = v;
        t.ill = il; t.seq = s; t.wrap = w; t.lock = l; t.err = er;
        return t;
    endfunction

    task automatic check_all(input string tag, input vec_t x);
        check({tag, " bin"},     32'(bin_out),    32'(x.bin));
        check({tag, " onehot"},  32'(onehot_out), 32'(x.oh));
        check({tag, " valid"},   32'(valid),      32'(x.valid));
        check({tag, " illegal"}, 32'(illegal),    32'(x.ill));
        check({tag, " seq_err"}, 32'(seq_err),    32'(x.seq));
        check({tag, " wrap"},    32'(wrap),       32'(x.wrap));
        check({tag, " locked"},  32'(locked),     32'(x.lock));
        check({tag, " err_cnt"}, 32'(err_cnt),    32'(x.err));
    endtask

    initial begin
        // en, jc, bin, onehot, valid, illegal, seq_err, wrap, locked, err_cnt
        vecs.push_back(mk(1, 3'b000, 0, 6'b000001, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 1, 6'b000010, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, 3, 6'b001000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 4, 6'b010000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b001, 5, 6'b100000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b000, 0, 6'b000001, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 3'b101, 0, 6'b000001, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b100, 1, 6'b000010, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, (i % 2 == 0) ? 3'b010 : 3'b101, 2, 6'b000100, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b010, 2, 6'b000000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b111, 3, 6'b001000, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b001, 5, 6'b100000, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1, 3'b000, 0, 6'b000001, 1, 0, 0, 1, 0, 2));
        vecs.push_back(mk(1, 3'b100, 1, 6'b000010, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 3'b111, 3, 6'b001000, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 1, 0, 0, 3));
        vecs.push_back(mk(0, 3'b000, 2, 6'b000100, 1, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, 3'b011, 4, 6'b010000, 1, 0, 1, 0, 0, 4));
        vecs.push_back(mk(1, 3'b000, 0, 6'b000001, 1, 0, 1, 0, 0, 5));
        vecs.push_back(mk(1, 3'b101, 0, 6'b000000, 0, 1, 0, 0, 0, 6));
        vecs.push_back(mk(1, 3'b010, 0, 6'b000000, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 3'b011, 4, 6'b010000, 1, 0, 0, 0, 0, 7));
        vecs.push_back(mk(1, 3'b001, 5, 6'b100000, 1, 0, 0, 0, 0, 7));
        vecs.push_back(mk(1, 3'b000, 0, 6'b000001, 1, 0, 0, 1, 0, 7));
        vecs.push_back(mk(1, 3'b100, 1, 6'b000010, 1, 0, 0, 0, 0, 7));
        vecs.push_back(mk(1, 3'b110, 2, 6'b000100, 1, 0, 0, 0, 1, 7));

        clr   = 1'b1;
        en    = 1'b0;
        jc_in = 3'b000;
        #2;
        check_all("reset", mk(0, 3'b000, 0, 6'b000000, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        clr = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            en    = vecs[i].en;
            jc_in = vecs[i].jc;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous clear between edges while locked with err_cnt=7.
        #3;
        clr = 1'b1;
        #1;
        check_all("async_clr", mk(0, 3'b000, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        en    = 1'b1;
        jc_in = 3'b111;
        @(posedge clk);
        #1;
        check_all("clr_wins", mk(0, 3'b000, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        clr   = 1'b0;
        jc_in = 3'b011;
        @(posedge clk);
        #1;
        check_all("post_clr0", mk(1, 3'b011, 4, 6'b010000, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        jc_in = 3'b001;
        @(posedge clk);
        #1;
        check_all("post_clr1", mk(1, 3'b001, 5, 6'b100000, 1, 0, 0, 0, 0, 0));

        // Alternating 000/111: every sample after the first is a sequence error.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en    = 1'b1;
            jc_in = (i % 2 == 0) ? 3'b000 : 3'b111;
            @(posedge clk);
            #1;
            check($sformatf("sat%0d seq_err", i), 32'(seq_err), (i > 0) ? 32'd1 : 32'd0);
            check($sformatf("sat%0d err_cnt", i), 32'(err_cnt), (i > 255) ? 32'd255 : 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
